// File: rtl/seq_add_pkg.sv
// Shared types and default widths for the sequenced nibble accumulator.
package seq_add_pkg;

    localparam int unsigned WORD_W = 4;
    localparam int unsigned ACC_W  = 12;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

endpackage

// File: rtl/seq_add_ctrl_if.sv
// Run-control, array-read and result signals of seq_add_ctrl.
// master = requester/memory/consumer side, slave = the controller.
interface seq_add_ctrl_if #(
    parameter int unsigned NUM_WORDS = 128,
    parameter int unsigned WORD_W    = 4,
    parameter int unsigned ACC_W     = 12
);
    localparam int unsigned AW = $clog2(NUM_WORDS);

    logic              start;
    logic              abort;
    logic [WORD_W-1:0] mask;
    logic [AW-1:0]     rd_addr;
    logic              rd_en;
    logic [WORD_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic [ACC_W-1:0]  sum;
    logic              ovf;

    modport master (
        output start, abort, mask, rd_data,
        input  rd_addr, rd_en, busy, done, sum, ovf
    );

    modport slave (
        input  start, abort, mask, rd_data,
        output rd_addr, rd_en, busy, done, sum, ovf
    );

endinterface

// File: rtl/seq_add_acc.sv
// Masked accumulator register with clear and enable.
// SEQ_ADD_CTRL_SAT_EN: saturate at all-ones and raise a sticky overflow flag.
module seq_add_acc #(
    parameter int unsigned WORD_W = seq_add_pkg::WORD_W,
    parameter int unsigned ACC_W  = seq_add_pkg::ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [WORD_W-1:0] word,
    input  logic [WORD_W-1:0] mask,
    output logic [ACC_W-1:0]  acc,
    output logic              ovf
);
    logic [ACC_W-1:0] acc_q;

`ifdef SEQ_ADD_CTRL_SAT_EN
    localparam int unsigned SumW = ACC_W + 1;

    logic [SumW-1:0] add_sum;
    logic            ovf_q;

    assign add_sum = {1'b0, acc_q} + SumW'(word & mask);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (clr) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (en) begin
            if (add_sum[ACC_W]) begin
                acc_q <= '1;
                ovf_q <= 1'b1;
            end else begin
                acc_q <= add_sum[ACC_W-1:0];
            end
        end
    end

    assign ovf = ovf_q;
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_q + ACC_W'(word & mask);
        end
    end

    assign ovf = 1'b0;
`endif

    assign acc = acc_q;

endmodule

// File: rtl/seq_add_ctrl.sv
// Bounded, restartable run over a NUM_WORDS-deep array: fetch, mask and accumulate,
// then pulse done. Optional saturation lives in seq_add_acc.
module seq_add_ctrl #(
    parameter int unsigned NUM_WORDS = 128,
    parameter int unsigned WORD_W    = seq_add_pkg::WORD_W,
    parameter int unsigned ACC_W     = seq_add_pkg::ACC_W
) (
    input  logic         clk,
    input  logic         rst,
    seq_add_ctrl_if.slave bus
);
    import seq_add_pkg::*;

    localparam int unsigned    AW       = $clog2(NUM_WORDS);
    localparam logic [AW-1:0] LastAddr = AW'(NUM_WORDS - 1);

    state_e            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [WORD_W-1:0] mask_q;
    logic              valid_q;
    logic              start_run;
    logic              abort_run;

    assign abort_run = bus.abort && (state_q != StIdle);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        start_run = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start && !bus.abort) begin
                    state_d   = StFetch;
                    addr_d    = '0;
                    start_run = 1'b1;
                end
            end
            StFetch: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else if (addr_q == LastAddr) begin
                    state_d = StDrain;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            StDrain: state_d = bus.abort ? StIdle : StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            mask_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            if (start_run) begin
                mask_q <= bus.mask;
            end
            // An abort discards the read already issued this cycle.
            valid_q <= (state_q == StFetch) && !bus.abort;
        end
    end

    assign bus.rd_addr = addr_q;
    assign bus.rd_en   = (state_q == StFetch);
    assign bus.busy    = (state_q != StIdle);
    assign bus.done    = (state_q == StDone) && !bus.abort;

    seq_add_acc #(
        .WORD_W (WORD_W),
        .ACC_W  (ACC_W)
    ) u_acc (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_run || abort_run),
        .en   (valid_q),
        .word (bus.rd_data),
        .mask (mask_q),
        .acc  (bus.sum),
        .ovf  (bus.ovf)
    );

endmodule

// File: tb/tb_seq_add_ctrl.sv
// Directed bench for seq_add_ctrl: a 128-word instance for function/control checks and a
// 300-word instance for the overflow case.
module tb_seq_add_ctrl;

    localparam int unsigned NA = 128;
    localparam int unsigned NB = 300;

    bit   clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seq_add_ctrl_if #(.NUM_WORDS(NA), .WORD_W(4), .ACC_W(12)) bus_a ();
    seq_add_ctrl_if #(.NUM_WORDS(NB), .WORD_W(4), .ACC_W(12)) bus_b ();

    seq_add_ctrl #(.NUM_WORDS(NA), .WORD_W(4), .ACC_W(12)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    seq_add_ctrl #(.NUM_WORDS(NB), .WORD_W(4), .ACC_W(12)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int n_chk = 0;
    int n_bad = 0;
    int pat_a = 0;

    int done_cyc, done_cnt, busy_err;
    logic ab_busy, ab_rd_en;
    logic [11:0] ab_sum;

    // 1-cycle-latency array models: pattern 0 = all 0xF, pattern 1 = i mod 16
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_a.rd_data <= 4'h0;
        end else if (bus_a.rd_en) begin
            bus_a.rd_data <= (pat_a == 0) ? 4'hF : bus_a.rd_addr[3:0];
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_b.rd_data <= 4'h0;
        end else if (bus_b.rd_en) begin
            bus_b.rd_data <= 4'hF;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Start a run on DUT A (cycle 0 = start sampled) and observe 140 cycles.
    task automatic run_a(input logic [3:0] m, input int restart_cyc, input int abort_cyc);
        done_cyc = -1;
        done_cnt = 0;
        busy_err = 0;
        @(negedge clk);
        bus_a.start = 1'b1;
        bus_a.mask  = m;
        for (int c = 1; c <= 140; c++) begin
            @(negedge clk);
            if (bus_a.done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (abort_cyc < 0 && bus_a.busy !== (c <= int'(NA) + 2)) busy_err++;
            if (abort_cyc >= 0 && c == abort_cyc + 1) begin
                ab_busy  = bus_a.busy;
                ab_rd_en = bus_a.rd_en;
                ab_sum   = bus_a.sum;
            end
            bus_a.start = (c == restart_cyc);
            if (c == restart_cyc) bus_a.mask = 4'h1;
            bus_a.abort = (c == abort_cyc);
        end
        bus_a.start = 1'b0;
        bus_a.abort = 1'b0;
    endtask

    initial begin
        int b_done;
        logic [31:0] exp_b_sum, exp_b_ovf;

        rst = 1'b0;
        bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.mask = 4'h0;
        bus_b.start = 1'b0; bus_b.abort = 1'b0; bus_b.mask = 4'h0;
        repeat (3) @(negedge clk);

        check_val("rst_busy",    32'(bus_a.busy),    0);
        check_val("rst_done",    32'(bus_a.done),    0);
        check_val("rst_sum",     32'(bus_a.sum),     0);
        check_val("rst_ovf",     32'(bus_a.ovf),     0);
        check_val("rst_rd_addr", 32'(bus_a.rd_addr), 0);
        check_val("rst_rd_en",   32'(bus_a.rd_en),   0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // All 0xF, mask 0xF
        pat_a = 0;
        run_a(4'hF, -1, -1);
        check_val("full_done_cyc", 32'(done_cyc), 130);
        check_val("full_done_cnt", 32'(done_cnt), 1);
        check_val("full_busy_err", 32'(busy_err), 0);
        check_val("full_sum",      32'(bus_a.sum), 1920);
        check_val("full_ovf",      32'(bus_a.ovf), 0);
        check_val("full_addr_hold", 32'(bus_a.rd_addr), 127);

        pat_a = 1;
        run_a(4'hF, -1, -1);
        check_val("ramp_sum", 32'(bus_a.sum), 960);

        pat_a = 0;
        run_a(4'h5, -1, -1);
        check_val("mask5_sum", 32'(bus_a.sum), 640);

        // Start (with a different mask) mid-run must be ignored
        run_a(4'hF, 50, -1);
        check_val("restart_done_cyc", 32'(done_cyc), 130);
        check_val("restart_done_cnt", 32'(done_cnt), 1);
        check_val("restart_sum",      32'(bus_a.sum), 1920);

        run_a(4'h1, -1, -1);
        check_val("mask1_sum", 32'(bus_a.sum), 128);

        // Abort during cycle 40
        run_a(4'hF, -1, 40);
        check_val("abort_busy",     32'(ab_busy),  0);
        check_val("abort_rd_en",    32'(ab_rd_en), 0);
        check_val("abort_sum",      32'(ab_sum),   0);
        check_val("abort_done_cnt", 32'(done_cnt), 0);

        // start and abort together in IDLE: no run
        @(negedge clk);
        bus_a.start = 1'b1;
        bus_a.abort = 1'b1;
        bus_a.mask  = 4'hF;
        @(negedge clk);
        bus_a.start = 1'b0;
        bus_a.abort = 1'b0;
        check_val("start_abort_idle", 32'(bus_a.busy), 0);

        // Asynchronous reset mid-FETCH
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("arst_busy",    32'(bus_a.busy),    0);
        check_val("arst_rd_en",   32'(bus_a.rd_en),   0);
        check_val("arst_rd_addr", 32'(bus_a.rd_addr), 0);
        check_val("arst_sum",     32'(bus_a.sum),     0);
        check_val("arst_ovf",     32'(bus_a.ovf),     0);
        check_val("arst_done",    32'(bus_a.done),    0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_val("arst_no_resume", 32'(bus_a.busy), 0);

        // 300 words of 0xF: 4500 overflows 12 bits
`ifdef SEQ_ADD_CTRL_SAT_EN
        exp_b_sum = 4095;
        exp_b_ovf = 1;
`else
        exp_b_sum = 404;
        exp_b_ovf = 0;
`endif
        b_done = -1;
        bus_b.start = 1'b1;
        bus_b.mask  = 4'hF;
        for (int c = 1; c <= 320; c++) begin
            @(negedge clk);
            bus_b.start = 1'b0;
            if (bus_b.done && b_done < 0) b_done = c;
        end
        check_val("big_done_cyc", 32'(b_done), 302);
        check_val("big_sum",      32'(bus_b.sum), exp_b_sum);
        check_val("big_ovf",      32'(bus_b.ovf), exp_b_ovf);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_add_ctrl.md
# seq_add_ctrl

Sequencing controller for the nibble accumulator datapath. On a start request it walks a NUM_WORDS-deep array of WORD_W-bit words held in an external 1-cycle-latency memory. It applies a per-run check mask to each word and accumulates the masked words into an ACC_W-bit sum. It reports completion with a done pulse. It sits between the array storage and the consumer of the masked sum, replacing free-running accumulation with a bounded, restartable, handshaked run.

## Interface
Parameters:
- NUM_WORDS, 128, number of array words per run (≥2)
- WORD_W, 4, word and mask width
- ACC_W, 12, accumulator and sum width
- AW, $clog2(NUM_WORDS), address width (derived, not overridden)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  run request; sampled only in IDLE
- abort  in  1  cancel the current run
- mask  in  WORD_W  check mask; captured on the start cycle
- rd_addr  out  AW  array read address
- rd_en  out  1  read strobe
- rd_data  in  WORD_W  word for the address issued one cycle earlier
- busy  out  1  run in progress
- done  out  1  one-cycle pulse; sum valid and final
- sum  out  ACC_W  accumulated masked sum; holds its value until the next start
- ovf  out  1  sticky overflow flag (see Configuration)

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - start=1 → capture mask, clear acc and ovf, go to FETCH.
  - Other inputs are ignored.
- FETCH:
  - rd_en=1; rd_addr runs 0..NUM_WORDS-1, incrementing by one per cycle.
  - After address NUM_WORDS-1 is issued, go to DRAIN.
- DRAIN: one cycle, waiting for the last word; rd_en=0; then go to DONE.
- DONE: done=1 for one cycle, then return to IDLE.
- Accumulation: on every cycle where the data-valid flag is set, acc ← acc + zero-extend(rd_data & mask_q), computed mod 2^ACC_W. The data-valid flag is rd_en delayed by one cycle.
- busy=1 in FETCH, DRAIN and DONE.
- start while busy: ignored; it is not queued.
- abort=1 in any non-IDLE state:
  - Next state is IDLE and no done pulse is produced.
  - The in-flight read is discarded.
  - acc is cleared to 0.
  - abort has priority over all other transitions.
- start and abort both asserted in IDLE: abort wins and no run starts.
- rst low (asynchronous):
  - State goes to IDLE; all outputs are 0, including sum, ovf and rd_addr.
  - A partial run is lost. After rst deasserts, a new start is required.

## Timing
- Cycle 0: start sampled in IDLE.
- Cycles 1..NUM_WORDS: rd_addr = 0..NUM_WORDS-1 with rd_en=1.
- Cycles 2..NUM_WORDS+1: rd_data is accumulated.
- Cycle NUM_WORDS+2: done=1, and sum holds the final value.
- Start-to-done latency is NUM_WORDS+2 cycles.
- The earliest next start is cycle NUM_WORDS+3, so back-to-back runs complete every NUM_WORDS+3 cycles.
- rd_addr holds its last value outside FETCH.

## Configuration
- SEQ_ADD_CTRL_SAT_EN defined:
  - The add saturates at 2^ACC_W-1.
  - ovf is set sticky on the first carry out and cleared on start or rst.
- SEQ_ADD_CTRL_SAT_EN undefined:
  - The add wraps mod 2^ACC_W.
  - ovf is tied to 0.

## Structure
- Shared package seq_add_pkg holds the state enum (IDLE, FETCH, DRAIN, DONE) and the default width constants WORD_W=4 and ACC_W=12.
- Sub-module seq_add_acc: the masked accumulator register with clear, enable and optional saturation. The FSM, address counter and valid pipeline stay in seq_add_ctrl.

## Test plan
- All words 0xF, mask 0xF, NUM_WORDS=128, start at cycle 0 → done at cycle 130, sum=1920, ovf=0, busy for cycles 1..130.
- Word i = i mod 16, mask 0xF → sum=960. With mask 0x5 and all words 0xF → sum=640.
- start re-asserted on cycle 50 of a run → ignored; single done at cycle 130 with the unchanged sum. Then a new start with mask 0x1 → sum=128.
- abort at cycle 40 → IDLE at cycle 41, no done, sum=0, rd_en=0. rst pulsed low mid-FETCH → all outputs 0 immediately.
- NUM_WORDS=300, all words 0xF, mask 0xF:
  - With SEQ_ADD_CTRL_SAT_EN → sum=4095, ovf=1.
  - Without SEQ_ADD_CTRL_SAT_EN → sum=404, ovf=0.
